// File: rtl/text_write_scheduler.sv
// text_write_scheduler
// Round-robin arbiter between the UART and keypad byte sources. Printable
// bytes go through the character-ID encoder and land at the cursor cell of
// the text-screen RAM. Backspace, carriage return and form feed are handled
// locally without the encoder.
module text_write_scheduler #(
   parameter int COLS     = 80,
   parameter int ROWS     = 30,
   parameter int ADDR_W   = 12,
   parameter int BLANK_ID = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid0,
   input  logic [7:0]        data0,
   output logic              ready0,
   input  logic              valid1,
   input  logic [7:0]        data1,
   output logic              ready1,
   output logic              enc_we,
   output logic [7:0]        enc_data,
   input  logic [7:0]        enc_char_id,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic [ADDR_W-1:0] cursor,
   output logic              busy
);

   localparam int CELLS = COLS * ROWS;
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
   localparam logic [7:0]        BLANK     = 8'(BLANK_ID);
   localparam logic [7:0]        CH_BS     = 8'h08;
   localparam logic [7:0]        CH_FF     = 8'h0C;
   localparam logic [7:0]        CH_CR     = 8'h0D;

   typedef enum logic [1:0] {IDLE, ENCODE, WRITE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic              last_grant;   // port granted most recently (1 = port 1)
   logic              grant1;       // current grant points at port 1
   logic              xfer;         // a byte moves this cycle
   logic [7:0]        in_byte;      // byte from the granted port
   logic [7:0]        byte_q;       // byte being processed
   logic [ADDR_W-1:0] clr_cnt;      // form-feed sweep address

   // Advance one cell, wrapping from the last cell of the screen to 0.
   function automatic logic [ADDR_W-1:0] cell_inc(input logic [ADDR_W-1:0] c);
      return (c == LAST_CELL) ? '0 : c + 1'b1;
   endfunction

   // First cell of the following row, wrapping from the last row to 0.
   function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] c);
      logic [ADDR_W-1:0] row;
      row = c / COLS_A;
      return (row >= LAST_ROW) ? '0 : (row + 1'b1) * COLS_A;
   endfunction

   // Round-robin grant; ready is only offered in IDLE and to one port at most.
   always_comb begin
      if (valid0 && valid1) grant1 = ~last_grant;
      else                  grant1 = valid1;
      ready0  = (state == IDLE) && valid0 && !grant1;
      ready1  = (state == IDLE) && valid1 && grant1;
      xfer    = ready0 || ready1;
      in_byte = grant1 ? data1 : data0;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode: control bytes bypass the encoder.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (xfer) begin
               case (in_byte)
                  CH_BS:   state_nxt = (cursor != '0) ? WRITE : IDLE;
                  CH_CR:   state_nxt = IDLE;
                  CH_FF:   state_nxt = CLEAR;
                  default: state_nxt = ENCODE;
               endcase
            end
         end
         ENCODE: state_nxt = WRITE;
         WRITE:  state_nxt = IDLE;
         CLEAR:  if (clr_cnt == LAST_CELL) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from state so an asynchronous reset drops them at once.
   always_comb begin
      enc_we   = 1'b0;
      enc_data = '0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      busy     = (state != IDLE);
      case (state)
         ENCODE: begin
            enc_we   = 1'b1;
            enc_data = byte_q;
         end
         WRITE: begin
            mem_we   = 1'b1;
            mem_addr = cursor;
            mem_data = (byte_q == CH_BS) ? BLANK : enc_char_id;
         end
         CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
            mem_data = BLANK;
         end
         default: ;
      endcase
   end

   // Accepted byte; only consumed in states entered after a transfer.
   always_ff @(posedge clock) begin
      if (xfer) byte_q <= in_byte;
   end

   // Cursor, clear counter and round-robin pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cursor     <= '0;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  last_grant <= grant1;
                  case (in_byte)
                     CH_BS:   if (cursor != '0) cursor <= cursor - 1'b1;
                     CH_CR:   cursor  <= next_row(cursor);
                     CH_FF:   clr_cnt <= '0;
                     default: ;
                  endcase
               end
            end
            WRITE: begin
               // Backspace already moved the cursor back on acceptance.
               if (byte_q != CH_BS) cursor <= cell_inc(cursor);
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_CELL) cursor <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler with a small encoder model.
module tb_text_write_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic [7:0]  data0 = 8'h00, data1 = 8'h00;
   logic        ready0, ready1, enc_we, mem_we, busy;
   logic [7:0]  enc_data, enc_char_id, mem_data;
   logic [11:0] mem_addr, cursor;

   int checks = 0;
   int failures = 0;
   int cnt0, cnt1, k, both, cyc;
   bit g;

   text_write_scheduler #(.COLS(80), .ROWS(30), .ADDR_W(12), .BLANK_ID(128)) dut (
      .clock(clock), .reset(reset),
      .valid0(valid0), .data0(data0), .ready0(ready0),
      .valid1(valid1), .data1(data1), .ready1(ready1),
      .enc_we(enc_we), .enc_data(enc_data), .enc_char_id(enc_char_id),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .cursor(cursor), .busy(busy)
   );

   always #5 clock = ~clock;

   // Encoder model: '0'-'9' -> 0..9, 'A'-'Z' -> 10..35, 'a'-'z' -> 36..61.
   function automatic logic [7:0] enc_map(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) return b - 8'h30;
      if (b >= 8'h41 && b <= 8'h5A) return b - 8'h41 + 8'd10;
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h61 + 8'd36;
      return 8'd99;
   endfunction

   always @(posedge clock) if (enc_we) enc_char_id <= enc_map(enc_data);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a byte, wait (bounded) for ready, let it transfer; returns at
   // the transfer edge + 1 time unit.
   task automatic xfer(input bit port, input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clock);
      if (!port) begin valid0 = 1'b1; data0 = b; end
      else       begin valid1 = 1'b1; data1 = b; end
      #1;
      while (((!port && !ready0) || (port && !ready1)) && n < 3000) begin
         @(negedge clock); #1; n++;
      end
      check("xfer_wait", 32'(n < 3000), 1);
      @(posedge clock); #1;
      if (!port) valid0 = 1'b0; else valid1 = 1'b0;
   endtask

   task automatic print(input logic [7:0] b);
      xfer(1'b0, b);
      @(posedge clock); @(posedge clock); #1;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_enc_we", enc_we, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_enc_data", enc_data, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_cursor", cursor, 0);
      @(negedge clock) reset = 1'b0;

      // Single printable character
      xfer(1'b0, 8'h41);
      check("a_enc_we", enc_we, 1);
      check("a_enc_data", enc_data, 8'h41);
      check("a_mem_we_t1", mem_we, 0);
      check("a_busy", busy, 1);
      @(posedge clock); #1;
      check("a_mem_we", mem_we, 1);
      check("a_mem_addr", mem_addr, 0);
      check("a_mem_data", mem_data, 10);
      check("a_enc_we_t2", enc_we, 0);
      @(posedge clock); #1;
      check("a_mem_we_t3", mem_we, 0);
      check("a_busy_t3", busy, 0);
      check("a_cursor", cursor, 1);

      // Fresh reset so the round-robin pointer favours port 0 again
      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      check("rst2_cursor", cursor, 0);

      // Contention: both ports hold 4 bytes each
      @(posedge clock); #1;
      valid0 = 1'b1; data0 = 8'h30;
      valid1 = 1'b1; data1 = 8'h61;
      cnt0 = 0; cnt1 = 0; k = 0; both = 0; cyc = 0;
      while (k < 8 && cyc < 200) begin
         #1;
         if (ready0 && ready1) both++;
         if (ready0 || ready1) begin
            g = ready1;
            check($sformatf("grant%0d", k), 32'(g), 32'(k % 2));
            k++;
            @(posedge clock); #1;
            if (!g) begin
               cnt0++;
               if (cnt0 == 4) valid0 = 1'b0; else data0 = 8'(8'h30 + cnt0);
            end else begin
               cnt1++;
               if (cnt1 == 4) valid1 = 1'b0; else data1 = 8'(8'h61 + cnt1);
            end
         end else begin
            @(posedge clock); #1;
         end
         cyc++;
      end
      check("grant_count", k, 8);
      check("both_ready", both, 0);
      @(posedge clock); @(posedge clock); #1;
      check("cont_cursor", cursor, 8);

      // Carriage returns and wrap
      xfer(1'b0, 8'h0D);
      check("cr_8", cursor, 80);
      repeat (5) print(8'h78);
      check("cursor_85", cursor, 85);
      xfer(1'b0, 8'h0D);
      check("cr_85", cursor, 160);
      repeat (27) xfer(1'b0, 8'h0D);
      check("cr_last_row", cursor, 2320);
      repeat (30) print(8'h78);
      check("cursor_2350", cursor, 2350);
      xfer(1'b0, 8'h0D);
      check("cr_wrap", cursor, 0);
      repeat (29) xfer(1'b0, 8'h0D);
      repeat (79) print(8'h79);
      check("cursor_2399", cursor, 2399);
      xfer(1'b0, 8'h30);
      @(posedge clock); #1;
      check("wrap_mem_we", mem_we, 1);
      check("wrap_mem_addr", mem_addr, 2399);
      check("wrap_mem_data", mem_data, 0);
      @(posedge clock); #1;
      check("wrap_cursor", cursor, 0);

      // Form feed with port 1 waiting
      xfer(1'b0, 8'h0C);
      valid1 = 1'b1; data1 = 8'h62;
      #1;
      for (int i = 0; i < 2400; i++) begin
         check($sformatf("clr%0d", i),
               {9'd0, mem_we, busy, ready1, mem_data, mem_addr},
               {9'd0, 1'b1, 1'b1, 1'b0, 8'd128, 12'(i)});
         @(posedge clock); #1;
      end
      check("ff_mem_we_end", mem_we, 0);
      check("ff_busy_end", busy, 0);
      check("ff_cursor", cursor, 0);
      check("ff_ready1", ready1, 1);
      @(posedge clock); #1;
      valid1 = 1'b0;
      check("ff_p1_enc_we", enc_we, 1);
      check("ff_p1_enc_data", enc_data, 8'h62);
      @(posedge clock); @(posedge clock); #1;
      check("ff_p1_cursor", cursor, 1);

      // Backspace
      repeat (4) print(8'h63);
      check("cursor_5", cursor, 5);
      xfer(1'b0, 8'h08);
      check("bs_mem_we", mem_we, 1);
      check("bs_mem_addr", mem_addr, 4);
      check("bs_mem_data", mem_data, 128);
      check("bs_enc_we", enc_we, 0);
      check("bs_cursor_t1", cursor, 4);
      @(posedge clock); #1;
      check("bs_mem_we_t2", mem_we, 0);
      check("bs_busy_t2", busy, 0);
      check("bs_cursor", cursor, 4);
      repeat (4) begin xfer(1'b0, 8'h08); @(posedge clock); #1; end
      check("bs_to_0", cursor, 0);
      xfer(1'b0, 8'h08);
      check("bs0_mem_we", mem_we, 0);
      check("bs0_busy", busy, 0);
      check("bs0_cursor", cursor, 0);

      // Reset in the middle of a clear
      print(8'h7A);
      check("z_cursor", cursor, 1);
      xfer(1'b0, 8'h0C);
      repeat (1000) @(posedge clock);
      #1;
      check("clr1000_addr", mem_addr, 1000);
      check("clr1000_we", mem_we, 1);
      check("clr1000_cursor", cursor, 1);
      reset = 1'b1;
      #1;
      check("rstclr_mem_we", mem_we, 0);
      check("rstclr_busy", busy, 0);
      check("rstclr_cursor", cursor, 0);
      check("rstclr_mem_addr", mem_addr, 0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;
      check("rstclr_no_write", mem_we, 0);
      xfer(1'b0, 8'h61);
      check("ra_enc_we", enc_we, 1);
      @(posedge clock); #1;
      check("ra_mem_we", mem_we, 1);
      check("ra_mem_addr", mem_addr, 0);
      check("ra_mem_data", mem_data, 36);
      @(posedge clock); #1;
      check("ra_cursor", cursor, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/text_write_scheduler.md
# text_write_scheduler

Arbitrates between two byte sources (UART receive path and on-board keypad path) for the single character-ID encoder and the text-screen RAM write port. Accepted printable bytes are sent through the encoder and the resulting character ID is written at the cursor. Control bytes (backspace, carriage return, form feed) are handled directly by this block without the encoder. The block sits between the input front-ends and the VGA text-mode screen buffer.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 30, rows per screen
- `ADDR_W`, 12, screen RAM address width; must satisfy COLS*ROWS ≤ 2^ADDR_W
- `BLANK_ID`, 128, character ID written for erased cells
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `valid0` in 1: requester 0 (UART) has a byte
- `data0` in 8: requester 0 byte
- `ready0` out 1: requester 0 byte accepted this cycle
- `valid1` in 1: requester 1 (keypad) has a byte
- `data1` in 8: requester 1 byte
- `ready1` out 1: requester 1 byte accepted this cycle
- `enc_we` out 1: write strobe to the encoder
- `enc_data` out 8: byte to the encoder
- `enc_char_id` in 8: encoder registered output, valid the cycle after `enc_we`
- `mem_we` out 1: screen RAM write strobe
- `mem_addr` out ADDR_W: screen RAM address
- `mem_data` out 8: character ID to write
- `cursor` out ADDR_W: current cursor cell, row-major
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- States: IDLE, ENCODE, WRITE, CLEAR.
- Transfer rule: a byte transfers at a rising edge where `valid`x and `ready`x are both 1.
- `ready`x is combinational. It is high only in IDLE, only for the granted port, and never for both ports in the same cycle.
- Arbitration is round-robin:
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted.
  - After reset, port 0 wins the first tie.
- The granted byte is latched on transfer. The next state depends on the byte:
  - 0x08 backspace: if cursor > 0, decrement the cursor, then go to WRITE with `BLANK_ID` at the new cursor, with no cursor advance. If cursor = 0, stay in IDLE and do nothing.
  - 0x0D carriage return: in IDLE, set the cursor to the start of the next row. After the last row it wraps to 0. No RAM write.
  - 0x0C form feed: go to CLEAR with a clear counter of 0.
  - Any other byte: go to ENCODE.
- ENCODE: `enc_we`=1 and `enc_data`=latched byte for exactly one cycle, then go to WRITE.
- WRITE:
  - `mem_we`=1, `mem_addr`=cursor.
  - `mem_data` is `enc_char_id` for printable bytes, or `BLANK_ID` for backspace.
  - After a printable byte, the cursor increments; from COLS*ROWS−1 it wraps to 0.
  - Then go to IDLE.
- CLEAR:
  - Each cycle: `mem_we`=1, `mem_addr`=counter, `mem_data`=`BLANK_ID`.
  - The counter runs 0..COLS*ROWS−1.
  - After the last address, set the cursor to 0 and go to IDLE.
- Bytes held on a non-granted port wait. `valid` must stay asserted and the data stable until `ready`; this block does not buffer.

## Timing
- Reset values: state IDLE, `cursor`=0, all strobes 0, `enc_data`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, round-robin pointer favours port 0.
- Printable byte accepted at edge T:
  - `enc_we` is high in cycle T+1.
  - `mem_we` is high in cycle T+2.
  - The cursor updates at edge T+3.
  - The next `ready` can be high in cycle T+3, giving a throughput of 1 byte per 3 cycles.
- Backspace: `mem_we` is high in cycle T+1 at cursor−1. The next `ready` can be high in cycle T+2.
- Carriage return: the cursor updates at edge T+1. The next `ready` can be high in cycle T+1.
- Form feed: `mem_we` is high for COLS*ROWS consecutive cycles, starting in cycle T+1. `busy` stays high throughout.
- Assertion during any non-IDLE state: `ready0`=`ready1`=0. Valid bytes arriving then are not lost; they are held by the source.
- Cursor arithmetic is modulo COLS*ROWS. Next-row computation is (cursor/COLS+1)·COLS, wrapped to 0 at the last row.
- `reset` mid-ENCODE, WRITE or CLEAR: the operation aborts immediately and all outputs return to reset values. No partial write is issued after reset deasserts.

## Test plan
- Single char: `valid0`, `data0`=0x41 ('A'), encoder model returns 10 → `enc_we` in T+1 with 0x41; `mem_we` in T+2 with addr 0, data 10; `cursor`=1.
- Contention: both valid for 4 bytes each, held continuously → grants alternate 0,1,0,1,… starting with port 0; never both `ready` in the same cycle.
- Wrap: cursor=2399, print '0' → write at 2399 with data 0, `cursor`=0. Carriage return at cursor 2350 → `cursor`=0. Carriage return at 85 → `cursor`=160.
- Backspace: at cursor 5 → write `BLANK_ID`=128 at addr 4, `cursor`=4. At cursor 0 → no `mem_we`, `cursor` stays 0.
- Form feed: 2400 consecutive `mem_we` cycles at addrs 0..2399, all data 128, `busy` high throughout, `cursor`=0 after; port 1 held valid is accepted only after the clear completes.
- Reset during CLEAR at counter 1000 → `mem_we` drops asynchronously, state IDLE, `cursor`=0; a following 'a' writes ID 36 at addr 0.
